// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port between instruction
// fetch (requester 0) and the load/store unit (requester 1).
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_valid_i,
  input  logic [AW-1:0] req0_addr_i,
  input  logic          req0_we_i,
  input  logic [DW-1:0] req0_wdata_i,
  output logic          req0_ready_o,
  input  logic          req1_valid_i,
  input  logic [AW-1:0] req1_addr_i,
  input  logic          req1_we_i,
  input  logic [DW-1:0] req1_wdata_i,
  output logic          req1_ready_o,
  output logic          rsp0_valid_o,
  output logic          rsp1_valid_o,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          mem_valid_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ready_i,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int unsigned CW = (TIMEOUT == 32'd0) ? 1 : $clog2(TIMEOUT + 32'd1);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 32'd0) ? '0 : CW'(TIMEOUT - 32'd1);
  localparam logic TO_EN = (TIMEOUT != 32'd0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic win0_s, win1_s, accept_s, timeout_s;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win0_s = 1'b0;
    win1_s = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      win0_s = last_q;
      win1_s = ~last_q;
    end else begin
      win0_s = req0_valid_i;
      win1_s = req1_valid_i;
    end
  end

  assign accept_s  = (state_q == ST_IDLE) && (win0_s || win1_s) && !rst_i;
  assign timeout_s = TO_EN && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mem_ready wins over timeout in the final wait cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ready_i || timeout_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; ready is held low while in reset.
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    mem_valid_o  = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready_o = win0_s && !rst_i;
        req1_ready_o = win1_s && !rst_i;
      end
      ST_BUSY: mem_valid_o = 1'b1;
      ST_RESP: begin
        rsp0_valid_o = ~owner_q;
        rsp1_valid_o = owner_q;
      end
      default: begin
        mem_valid_o = 1'b0;
      end
    endcase
  end

  // Datapath next-state: latch on accept, capture result on BUSY exit.
  always_comb begin
    last_d      = last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          owner_d     = win1_s;
          cnt_d       = '0;
          mem_addr_d  = win1_s ? req1_addr_i  : req0_addr_i;
          mem_we_d    = win1_s ? req1_we_i    : req0_we_i;
          mem_wdata_d = win1_s ? req1_wdata_i : req0_wdata_i;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_BUSY: begin
        if (mem_ready_i) begin
          rsp_rdata_d = mem_rdata_i;
          rsp_err_d   = 1'b0;
        end else if (timeout_s) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RESP: last_d = owner_q;
      default: begin
        last_d = last_q;
      end
    endcase
  end

  // Datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      last_q      <= last_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
